pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, 0, PC value loaded by reset.
REQ-003 SHALL have parameter TRAP_VEC, 32'h100, PC value loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter IALIGN, 4, instruction alignment and sequential increment in bytes; legal values 2 or 4.
REQ-005 SHALL have port clk input 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset input 1: synchronous, active-high reset.
REQ-007 SHALL have port pc_write input 1: enables a sequential or redirect update this cycle.
REQ-008 SHALL have port redirect input 1: with pc_write, selects redirect_pc over sequential increment.
REQ-009 SHALL have port redirect_pc input XLEN: branch/jump target.
REQ-010 SHALL have port trap_req input 1: take a trap this cycle, independent of pc_write.
REQ-011 SHALL have port mret_req input 1: return to epc this cycle, independent of pc_write.
REQ-012 SHALL have port halt_req input 1: enter HALT.
REQ-013 SHALL have port resume input 1: leave HALT.
REQ-014 SHALL have port pc output XLEN: current program counter.
REQ-015 SHALL have port old_pc output XLEN: pc value held before its most recent change.
REQ-016 SHALL have port epc output XLEN: pc saved by the last trap.
REQ-017 SHALL have port misalign output 1: one-cycle pulse for a rejected misaligned redirect.
REQ-018 SHALL have port halted output 1: high while in HALT.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, HALT; reset enters BOOT; BOOT goes to RUN after exactly one cycle, ignoring all requests.
REQ-020 In RUN, the next-pc priority SHALL be trap_req > mret_req > (pc_write & redirect) > pc_write sequential > hold.
REQ-021 Sequential update SHALL be pc + IALIGN, modulo 2^XLEN (wrap to 0 from the top address).
REQ-022 trap_req SHALL set epc to the current pc and pc to TRAP_VEC.
REQ-023 mret_req SHALL set pc to epc; epc SHALL remain unchanged.
REQ-024 A redirect whose redirect_pc is not IALIGN-aligned SHALL be treated as a trap: epc gets the current pc, pc gets TRAP_VEC, misalign is high for the following cycle only.
REQ-025 Whenever pc changes value, old_pc SHALL take the previous pc in the same edge; otherwise old_pc holds.
REQ-026 halt_req in RUN SHALL move the FSM to HALT at the next edge, with pc frozen; a simultaneous trap_req or redirect still updates pc on that edge.
REQ-027 In HALT, pc, old_pc and epc SHALL hold; all inputs except resume and reset SHALL be ignored; resume returns the FSM to RUN at the next edge.
REQ-028 halted SHALL be a registered output, high exactly while the FSM state is HALT.
REQ-029 Latency from any request to a visible pc change SHALL be one clock edge.

Reset
REQ-030 reset SHALL dominate every other input, in any state, and mid-operation.
REQ-031 Reset values SHALL be: pc=RESET_VEC, old_pc=RESET_VEC, epc=0, misalign=0, halted=0, state=BOOT.

Structure
REQ-032 The state enum and the default vector constants SHALL live in shared package pc_pkg.
REQ-033 The next-pc priority and the alignment check SHALL be a combinational sub-module pc_next_sel; the registers and FSM SHALL stay in pc_unit.

Verification
REQ-034 Reset, release, then pc_write=1 for 3 cycles -> pc: 0 during BOOT, then 4, 8, 12; old_pc lags pc by one update.
REQ-035 pc=32'hFFFF_FFFC with pc_write=1 -> pc=0 and old_pc=32'hFFFF_FFFC.
REQ-036 pc=8, redirect_pc=32'h40 with redirect=1 and pc_write=1 -> pc=32'h40; with redirect_pc=32'h42 -> pc=32'h100, epc=8, misalign pulses for 1 cycle.
REQ-037 pc=32'h20 with trap_req and redirect both active -> pc=32'h100 and epc=32'h20; then mret_req -> pc=32'h20.
REQ-038 halt_req in RUN, then pc_write and trap_req for 5 cycles -> pc unchanged and halted=1; resume -> halted=0 and pc updates on the next pc_write.
REQ-039 Reset asserted while in HALT with trap_req active -> pc=RESET_VEC, state BOOT, epc=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam int          DEF_IALIGN    = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc selection: trap > mret > redirect > sequential > hold,
// with misaligned redirect targets turned into a trap.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
  parameter int              IALIGN   = DEF_IALIGN
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic            allow_seq,
  output logic [XLEN-1:0] next_pc,
  output logic            save_epc,
  output logic            misalign_hit
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);

  logic redirect_bad;

  assign redirect_bad = (redirect_pc & ALIGN_MASK) != '0;

  always_comb begin
    next_pc      = pc;
    save_epc     = 1'b0;
    misalign_hit = 1'b0;
    if (trap_req) begin
      next_pc  = TRAP_VEC;
      save_epc = 1'b1;
    end else if (mret_req) begin
      next_pc = epc;
    end else if (pc_write && redirect) begin
      if (redirect_bad) begin
        next_pc      = TRAP_VEC;
        save_epc     = 1'b1;
        misalign_hit = 1'b1;
      end else begin
        next_pc = redirect_pc;
      end
    end else if (pc_write && allow_seq) begin
      // Sum is truncated to XLEN, so the top address wraps to 0.
      next_pc = pc + STEP;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with trap/mret/redirect handling and a BOOT/RUN/HALT FSM.
// Every request becomes visible on pc at the next rising edge.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              IALIGN    = DEF_IALIGN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_req,
  input  logic            mret_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] epc,
  output logic            misalign,
  output logic            halted,
  output pc_state_e       state_dbg
);

  pc_state_e       state, state_next;
  logic            active, allow_seq;
  logic [XLEN-1:0] next_pc;
  logic            save_epc, misalign_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  if (halt_req) state_next = ST_HALT;
      ST_HALT: if (resume)   state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // On the halting edge only the plain increment is suppressed; trap,
  // mret and redirect still land.
  always_comb begin
    active    = (state == ST_RUN);
    allow_seq = !halt_req;
    state_dbg = state;
  end

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC),
    .IALIGN   (IALIGN)
  ) u_next_sel (
    .pc           (pc),
    .epc          (epc),
    .pc_write     (pc_write),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .trap_req     (trap_req),
    .mret_req     (mret_req),
    .allow_seq    (allow_seq),
    .next_pc      (next_pc),
    .save_epc     (save_epc),
    .misalign_hit (misalign_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VEC;
      old_pc   <= RESET_VEC;
      epc      <= '0;
      misalign <= 1'b0;
      halted   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      halted   <= (state_next == ST_HALT);
      if (active) begin
        misalign <= misalign_hit;
        if (save_epc) epc <= pc;
        // old_pc only moves when pc really changes value.
        if (next_pc != pc) begin
          old_pc <= pc;
          pc     <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vectors, a behavioural reference model checked
// every cycle, and literal expectations pinning the model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  logic        clk = 1'b0;
  logic        reset, pc_write, redirect, trap_req, mret_req, halt_req, resume;
  logic [31:0] redirect_pc;
  logic [31:0] pc, old_pc, epc;
  logic        misalign, halted;
  pc_state_e   state_dbg;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // clock/reset block
  always #5 clk = ~clk;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .trap_req    (trap_req),
    .mret_req    (mret_req),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .old_pc      (old_pc),
    .epc         (epc),
    .misalign    (misalign),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  // reference model: mode 0 = booting, 1 = running, 2 = halted
  logic [31:0] m_pc, m_old, m_epc, m_np;
  logic        m_mis;
  int          m_mode;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = RV; m_old = RV; m_epc = 32'h0; m_mis = 1'b0; m_mode = 0;
    end else if (m_mode == 0) begin
      m_mis = 1'b0; m_mode = 1;
    end else if (m_mode == 2) begin
      m_mis = 1'b0;
      if (resume) m_mode = 1;
    end else begin
      m_np  = m_pc;
      m_mis = 1'b0;
      if (trap_req) begin
        m_epc = m_pc; m_np = TV;
      end else if (mret_req) begin
        m_np = m_epc;
      end else if (pc_write && redirect) begin
        if (redirect_pc % 4 != 0) begin
          m_epc = m_pc; m_np = TV; m_mis = 1'b1;
        end else begin
          m_np = redirect_pc;
        end
      end else if (pc_write && !halt_req) begin
        m_np = 32'(64'(m_pc) + 64'd4);
      end
      if (m_np != m_pc) begin
        m_old = m_pc; m_pc = m_np;
      end
      if (halt_req) m_mode = 2;
    end
  end

  // scoreboard compare process, every cycle away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (pc !== m_pc || old_pc !== m_old || epc !== m_epc || misalign !== m_mis ||
          halted !== (m_mode == 2) || int'(state_dbg) !== m_mode) begin
        errors++;
        $display("FAIL model t=%0t: pc=%h/%h old=%h/%h epc=%h/%h mis=%b/%b halted=%b/%b state=%0d/%0d (actual/required)",
                 $time, pc, m_pc, old_pc, m_old, epc, m_epc, misalign, m_mis,
                 halted, (m_mode == 2), int'(state_dbg), m_mode);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit w, input bit r, input logic [31:0] rpc,
                       input bit t, input bit m, input bit h, input bit res);
    pc_write = w; redirect = r; redirect_pc = rpc;
    trap_req = t; mret_req = m; halt_req = h; resume = res;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    check_en = 1'b1;
    chk("reset_pc", pc, RV);
    chk("reset_old", old_pc, RV);
    chk("reset_epc", epc, 32'h0);
    chk("reset_mis", 32'(misalign), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_state", 32'(state_dbg), 32'(ST_BOOT));

    // boot cycle then sequential increments
    reset = 1'b0;
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    tick(); chk("boot_pc", pc, 32'h0);
    tick(); chk("seq1_pc", pc, 32'h4);
    tick(); chk("seq2_pc", pc, 32'h8); chk("seq2_old", old_pc, 32'h4);
    tick(); chk("seq3_pc", pc, 32'hC); chk("seq3_old", old_pc, 32'h8);

    // wrap at the top address
    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    tick(); chk("top_pc", pc, 32'hFFFF_FFFC);
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_old", old_pc, 32'hFFFF_FFFC);

    // aligned and misaligned redirect
    drive(1, 1, 32'h8, 0, 0, 0, 0); tick();
    drive(1, 1, 32'h40, 0, 0, 0, 0);
    tick(); chk("redir_pc", pc, 32'h40); chk("redir_old", old_pc, 32'h8);
    drive(1, 1, 32'h8, 0, 0, 0, 0); tick();
    drive(1, 1, 32'h42, 0, 0, 0, 0);
    tick(); chk("mis_pc", pc, TV); chk("mis_epc", epc, 32'h8); chk("mis_pulse", 32'(misalign), 32'h1);
    idle();
    tick(); chk("mis_drop", 32'(misalign), 32'h0); chk("mis_hold_pc", pc, TV);

    // trap beats redirect, then mret
    drive(1, 1, 32'h20, 0, 0, 0, 0); tick();
    drive(1, 1, 32'h40, 1, 0, 0, 0);
    tick(); chk("trap_pc", pc, TV); chk("trap_epc", epc, 32'h20);
    drive(0, 0, 32'h0, 0, 1, 0, 0);
    tick(); chk("mret_pc", pc, 32'h20); chk("mret_epc", epc, 32'h20);

    // halt: requests ignored while halted
    drive(0, 0, 32'h0, 0, 0, 1, 0);
    tick(); chk("halt_flag", 32'(halted), 32'h1); chk("halt_pc", pc, 32'h20);
    drive(1, 1, 32'h80, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("halt_frozen_pc", pc, 32'h20);
    end
    chk("halt_frozen_epc", epc, 32'h20);
    drive(0, 0, 32'h0, 0, 0, 0, 1);
    tick(); chk("resume_flag", 32'(halted), 32'h0);
    drive(1, 0, 32'h0, 0, 0, 0, 0);
    tick(); chk("resume_seq", pc, 32'h24);

    // redirect lands on the halting edge
    drive(1, 1, 32'h80, 0, 0, 1, 0);
    tick(); chk("halt_redir_pc", pc, 32'h80); chk("halt_redir_flag", 32'(halted), 32'h1);
    drive(0, 0, 32'h0, 0, 0, 0, 1); tick();

    // reset while halted with a trap pending
    drive(0, 0, 32'h0, 0, 0, 1, 0); tick();
    drive(0, 0, 32'h0, 1, 0, 0, 0);
    reset = 1'b1;
    tick(); chk("rst_halt_pc", pc, RV); chk("rst_halt_epc", epc, 32'h0);
    chk("rst_halt_state", 32'(state_dbg), 32'(ST_BOOT));
    reset = 1'b0;
    tick(); chk("boot_ignores_trap", pc, RV);
    tick(); chk("post_boot_trap", pc, TV);

    // randomised burst against the model
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1),
            {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3) == 0 ? 2 : 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
